// File: rtl/hmmm_pkg.sv
// Shared types for the hmmm core: instruction format, ALU ops and the
// memory-port response owner used by the arbiter.
package hmmm_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_PASS
  } alu_op_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] imm;
  } instr_t;

  // Who gets the RAM read data (or store ack) in the cycle after a grant
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_DATA_RD,
    OWN_DATA_WR
  } resp_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one single-port RAM with a
// fixed one-cycle response latency; data wins unless fetch has starved.
module mem_port_arbiter
  import hmmm_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  output logic              f_resp_valid,
  output logic [DATA_W-1:0] f_resp_data,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  resp_owner_t owner_q, owner_d;
  logic [3:0]  starve_cnt, starve_cnt_next;
  logic        f_grant, d_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      owner_q    <= owner_d;
      starve_cnt <= starve_cnt_next;
    end
  end

  // Grant selection drives the RAM directly and records who owns next cycle's data
  always_comb begin
    f_grant         = 1'b0;
    d_grant         = 1'b0;
    owner_d         = OWN_NONE;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    starve_cnt_next = '0;

    if (!reset) begin
      if (f_req_valid && (!d_req_valid || starve_cnt == LIMIT)) begin
        f_grant = 1'b1;
      end else if (d_req_valid) begin
        d_grant = 1'b1;
      end
    end

    if (f_grant) begin
      mem_en   = 1'b1;
      mem_addr = f_req_addr;
      owner_d  = OWN_FETCH;
    end else if (d_grant) begin
      mem_en    = 1'b1;
      mem_we    = d_req_we;
      mem_addr  = d_req_addr;
      mem_wdata = d_req_wdata;
      owner_d   = d_req_we ? OWN_DATA_WR : OWN_DATA_RD;
    end

    if (f_req_valid && !f_grant) begin
      starve_cnt_next = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
    end
  end

  assign f_req_ready = f_grant;
  assign d_req_ready = d_grant;

  // Reset suppresses a response that was already in flight
  always_comb begin
    f_resp_valid = 1'b0;
    f_resp_data  = '0;
    d_resp_valid = 1'b0;
    d_resp_data  = '0;
    if (!reset) begin
      case (owner_q)
        OWN_FETCH: begin
          f_resp_valid = 1'b1;
          f_resp_data  = mem_rdata;
        end
        OWN_DATA_RD: begin
          d_resp_valid = 1'b1;
          d_resp_data  = mem_rdata;
        end
        OWN_DATA_WR: d_resp_valid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a behavioural RAM plus a
// requester-level reference model that predicts grants and responses.
module tb_mem_port_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req_valid, f_req_ready, f_resp_valid;
  logic [AW-1:0] f_req_addr;
  logic [DW-1:0] f_resp_data;
  logic          d_req_valid, d_req_we, d_req_ready, d_resp_valid;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata, d_resp_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic          init_we = 1'b0;
  logic [AW-1:0] init_addr = '0;
  logic [DW-1:0] init_data = '0;

  logic [DW-1:0] ram     [256];
  logic [DW-1:0] ref_mem [256];

  int            checks = 0;
  int            errors = 0;
  int            deny_cnt = 0;
  int            obs_deny = 0;
  int            pend_kind = 0;
  logic [DW-1:0] pend_data = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port synchronous RAM with a preload path used only during reset
  always @(posedge clk) begin
    if (init_we) ram[init_addr] <= init_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check everything against the model, then advance the model
  task automatic applyStimulus(input logic rst, input logic fv, input logic [AW-1:0] fa,
                               input logic dv, input logic dwe, input logic [AW-1:0] da,
                               input logic [DW-1:0] dwd);
    int g;
    int ek;
    @(posedge clk);
    #1;
    reset = rst; f_req_valid = fv; f_req_addr = fa;
    d_req_valid = dv; d_req_we = dwe; d_req_addr = da; d_req_wdata = dwd;
    @(negedge clk);

    if (rst) g = 0;
    else if (fv && (!dv || deny_cnt >= LIMIT)) g = 1;
    else if (dv) g = 2;
    else g = 0;
    ek = rst ? 0 : pend_kind;

    checkOutput("f_req_ready", 32'(f_req_ready), 32'(g == 1));
    checkOutput("d_req_ready", 32'(d_req_ready), 32'(g == 2));
    checkOutput("ready_excl", 32'(f_req_ready & d_req_ready), 32'd0);
    checkOutput("mem_en", 32'(mem_en), 32'(g != 0));
    checkOutput("mem_we", 32'(mem_we), 32'(g == 2 && dwe));
    checkOutput("mem_addr", 32'(mem_addr), (g == 1) ? 32'(fa) : (g == 2) ? 32'(da) : 32'd0);
    checkOutput("mem_wdata", 32'(mem_wdata), (g == 2) ? 32'(dwd) : 32'd0);
    checkOutput("f_resp_valid", 32'(f_resp_valid), 32'(ek == 1));
    checkOutput("f_resp_data", 32'(f_resp_data), (ek == 1) ? 32'(pend_data) : 32'd0);
    checkOutput("d_resp_valid", 32'(d_resp_valid), 32'(ek == 2 || ek == 3));
    checkOutput("d_resp_data", 32'(d_resp_data), (ek == 2) ? 32'(pend_data) : 32'd0);

    if (!rst && fv && !f_req_ready) obs_deny++;
    else obs_deny = 0;
    checkOutput("starve_bound", 32'(obs_deny <= LIMIT), 32'd1);

    if (rst) begin
      deny_cnt  = 0;
      pend_kind = 0;
      pend_data = '0;
    end else begin
      pend_data = '0;
      pend_kind = 0;
      if (g == 1) begin
        pend_kind = 1;
        pend_data = ref_mem[fa];
      end else if (g == 2) begin
        if (dwe) begin
          pend_kind  = 3;
          ref_mem[da] = dwd;
        end else begin
          pend_kind = 2;
          pend_data = ref_mem[da];
        end
      end
      if (fv && g != 1) deny_cnt = (deny_cnt + 1 > LIMIT) ? LIMIT : deny_cnt + 1;
      else deny_cnt = 0;
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] v;
    reset = 1'b1; f_req_valid = 1'b0; f_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;

    for (int i = 0; i < 256; i++) begin
      v = (i == 5) ? 16'h1234 : DW'($urandom);
      @(posedge clk);
      #1;
      init_we = 1'b1; init_addr = AW'(i); init_data = v;
      ref_mem[i] = v;
    end
    @(posedge clk);
    #1;
    init_we = 1'b0;

    applyStimulus(1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h02, '0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Single fetch from a known word
    applyStimulus(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, '0, '0);
    checkOutput("fetch_ready_same_cycle", 32'(f_req_ready), 32'd1);
    idle();
    checkOutput("fetch_resp_data", 32'(f_resp_data), 32'h1234);
    checkOutput("fetch_no_d_resp", 32'(d_resp_valid), 32'd0);

    // Both requesters continuously valid: D,D,D,D,F repeating
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, AW'(i), 1'b1, 1'b0, AW'(i + 32), '0);
      checkOutput("starve_pattern", 32'(f_req_ready), 32'((i % 5) == 4));
    end
    idle();

    // Store then load to the same word on back-to-back cycles
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 8'h10, 16'hBEEF);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h10, '0);
    checkOutput("store_ack_valid", 32'(d_resp_valid), 32'd1);
    checkOutput("store_ack_data", 32'(d_resp_data), 32'd0);
    idle();
    checkOutput("load_after_store", 32'(d_resp_data), 32'hBEEF);

    // Reset in the cycle after a fetch grant drops the fetch response
    applyStimulus(1'b0, 1'b1, 8'h07, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b1, 8'h08, 1'b0, 1'b0, '0, '0);
    checkOutput("reset_drops_resp", 32'(f_resp_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 8'h0A, '0);
    checkOutput("post_reset_no_resp", 32'(f_resp_valid), 32'd0);
    checkOutput("post_reset_data_first", 32'(d_req_ready), 32'd1);
    idle();

    // Random traffic over a small address window to provoke hazards
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom_range(255) == 0),
                    ($urandom_range(3) != 0), AW'($urandom_range(15)),
                    ($urandom_range(3) != 0), 1'($urandom), AW'($urandom_range(15)),
                    DW'($urandom));
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
